// File: rtl/flag_period_checker.sv
// Monitors a divider flag: measures rising-edge spacing, locks on DIV_EXP, flags faults.
// Latency: all outputs registered, one cycle after the deciding edge/cycle.
// No backpressure: a passive monitor that samples flag_in every cycle.
module flag_period_checker #(
    parameter int DIV_EXP  = 5,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             flag_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        LOCK  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int                GOOD_W  = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  EXP     = CNT_W'(DIV_EXP);
    localparam logic [CNT_W-1:0]  EXP_P1  = CNT_W'(DIV_EXP + 1);
    localparam logic [GOOD_W-1:0] LOCK_M1 = GOOD_W'(LOCK_CNT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              flag_d;
    logic              rise;
    logic [CNT_W-1:0]  cnt;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_nxt;
    logic              fault;
    logic              report;

    // A flag held high for several cycles produces only one rising edge.
    assign rise = flag_in & ~flag_d;

    // Next-state, good-period tracking and fault decision for the current cycle.
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        fault     = 1'b0;
        report    = 1'b0;
        case (state)
            IDLE: begin
                // First edge only starts the measurement; there is no period yet.
                if (rise) begin
                    state_nxt = MEAS;
                    good_nxt  = '0;
                end
            end
            MEAS: begin
                if (rise) begin
                    report = 1'b1;
                    if (cnt == EXP) begin
                        if (good == LOCK_M1) begin
                            state_nxt = LOCK;
                            good_nxt  = '0;
                        end else begin
                            good_nxt = good + 1'b1;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
            end
            LOCK: begin
                report = rise;
                // Early/late edge, or a missing edge once cnt passes DIV_EXP.
                if ((rise && (cnt != EXP)) || (!rise && (cnt == EXP_P1))) begin
                    fault     = 1'b1;
                    state_nxt = FAULT;
                    good_nxt  = '0;
                end
            end
            FAULT: begin
                // Re-synchronise on the next edge; its period does not count as good.
                if (rise) begin
                    report    = 1'b1;
                    state_nxt = MEAS;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                good_nxt  = '0;
            end
        endcase
    end

    // State, good-period count, edge-detect delay and the saturating period counter.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= IDLE;
            good   <= '0;
            flag_d <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            good   <= good_nxt;
            flag_d <= flag_in;
            if (rise) begin
                cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (state != IDLE && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Registered outputs; locked drops in the same cycle that err pulses.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            period_out <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            period_vld <= report;
            if (report) begin
                period_out <= cnt;
            end
            locked <= (state_nxt == LOCK);
            err    <= fault;
            if (fault && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_flag_period_checker.sv
// Randomised bench for flag_period_checker: three instances checked every cycle against a reference model.
// Model works from edge timestamps (period = now - last edge), not from a counter.
// Flags driven on the falling edge; outputs compared on the falling edge.
module tb_flag_period_checker;

    localparam int N       = 3;
    localparam int M_IDLE  = 0;
    localparam int M_HUNT  = 1;
    localparam int M_LOCK  = 2;
    localparam int M_FAULT = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] flag;
    logic [7:0]   po0;
    logic [3:0]   po1;
    logic [7:0]   po2;
    logic [N-1:0] vld;
    logic [N-1:0] lk;
    logic [N-1:0] er;
    logic [7:0]   ec0;
    logic [7:0]   ec1;
    logic [7:0]   ec2;

    int vectors     = 0;
    int miscompares = 0;

    // Instance a: divide-by-5 reference case.
    flag_period_checker #(.DIV_EXP(5), .CNT_W(8), .LOCK_CNT(4)) u_a (
        .sys_clk(clk), .sys_rst(rst), .flag_in(flag[0]), .period_out(po0),
        .period_vld(vld[0]), .locked(lk[0]), .err(er[0]), .err_cnt(ec0));
    // Instance b: fastest legal period, single-period lock, narrow counter for saturation.
    flag_period_checker #(.DIV_EXP(2), .CNT_W(4), .LOCK_CNT(1)) u_b (
        .sys_clk(clk), .sys_rst(rst), .flag_in(flag[1]), .period_out(po1),
        .period_vld(vld[1]), .locked(lk[1]), .err(er[1]), .err_cnt(ec1));
    // Instance c: divide-by-6 with a 50% duty flag.
    flag_period_checker #(.DIV_EXP(6), .CNT_W(8), .LOCK_CNT(4)) u_c (
        .sys_clk(clk), .sys_rst(rst), .flag_in(flag[2]), .period_out(po2),
        .period_vld(vld[2]), .locked(lk[2]), .err(er[2]), .err_cnt(ec2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int i);
        return (i == 0) ? 5 : ((i == 1) ? 2 : 6);
    endfunction
    function automatic int lck_of(input int i);
        return (i == 1) ? 1 : 4;
    endfunction
    function automatic int max_of(input int i);
        return (i == 1) ? 15 : 255;
    endfunction
    function automatic string nm(input int i);
        return (i == 0) ? "a" : ((i == 1) ? "b" : "c");
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int t;
    int m_mode [N];
    int m_run  [N];
    int m_last [N];
    int m_errs [N];
    int m_per  [N];
    bit m_prev [N];
    bit m_vld  [N];
    bit m_err  [N];

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N; i++) begin
            m_mode[i] = M_IDLE; m_run[i] = 0; m_last[i] = 0; m_errs[i] = 0;
            m_per[i] = 0; m_prev[i] = 1'b0; m_vld[i] = 1'b0; m_err[i] = 1'b0;
        end
    endtask

    // Predict the outputs after the coming rising edge, given the flag sampled there.
    task automatic model_step(input int i, input bit f);
        bit rise;
        bit flt;
        int el;
        int per;
        rise      = f && !m_prev[i];
        m_prev[i] = f;
        el        = t - m_last[i];
        per       = (el > max_of(i)) ? max_of(i) : el;
        m_vld[i]  = 1'b0;
        m_err[i]  = 1'b0;
        flt       = 1'b0;
        if (m_mode[i] == M_IDLE) begin
            if (rise) begin
                m_mode[i] = M_HUNT; m_run[i] = 0; m_last[i] = t;
            end
        end else if (rise) begin
            m_vld[i] = 1'b1; m_per[i] = per; m_last[i] = t;
            if (m_mode[i] == M_HUNT) begin
                if (per == div_of(i)) begin
                    m_run[i]++;
                    if (m_run[i] >= lck_of(i)) m_mode[i] = M_LOCK;
                end else begin
                    m_run[i] = 0;
                end
            end else if (m_mode[i] == M_LOCK) begin
                if (per != div_of(i)) flt = 1'b1;
            end else begin
                m_mode[i] = M_HUNT; m_run[i] = 0;
            end
        end else if (m_mode[i] == M_LOCK && el == div_of(i) + 1) begin
            flt = 1'b1;
        end
        if (flt) begin
            m_mode[i] = M_FAULT; m_err[i] = 1'b1; m_run[i] = 0;
            if (m_errs[i] < 255) m_errs[i]++;
        end
    endtask

    // ---------------- flag generators ----------------
    int phase;
    int g_pos [N];
    int g_gap [N];
    int g_wid [N];
    int g_idx [N];

    task automatic pick_gap(input int i);
        int d;
        int r;
        d = div_of(i);
        g_gap[i] = d;
        g_wid[i] = (i == 2) ? 3 : 1;
        if (phase == 0) begin
            // Instance a: omitted pulse, then an early pulse followed by a short gap.
            if (i == 0) begin
                if (g_idx[i] == 10) g_gap[i] = 10;
                else if (g_idx[i] == 18) g_gap[i] = 3;
                else if (g_idx[i] == 19) g_gap[i] = 2;
            end
        end else if (phase == 1) begin
            r = $urandom_range(0, 9);
            if (r == 7) g_gap[i] = $urandom_range(2, d + 3);
            else if (r == 8) g_gap[i] = $urandom_range(d + 2, 2 * d + 2);
            else if (r == 9) g_gap[i] = $urandom_range(2, 30);
            g_wid[i] = $urandom_range(1, g_gap[i] - 1);
        end else begin
            // Instance b alternates good period and a missed pulse: one fault episode per pair.
            if (i == 1) g_gap[i] = (g_idx[i] % 2 == 0) ? 2 : 4;
        end
        g_idx[i]++;
    endtask

    task automatic gen_reset(input int ph);
        phase = ph;
        for (int i = 0; i < N; i++) begin
            g_pos[i] = 0; g_idx[i] = 0; g_gap[i] = 2; g_wid[i] = 1;
        end
    endtask

    task automatic compare_all();
        check({nm(0), ".period_out"}, {24'd0, po0}, m_per[0]);
        check({nm(1), ".period_out"}, {28'd0, po1}, m_per[1]);
        check({nm(2), ".period_out"}, {24'd0, po2}, m_per[2]);
        check({nm(0), ".err_cnt"}, {24'd0, ec0}, m_errs[0]);
        check({nm(1), ".err_cnt"}, {24'd0, ec1}, m_errs[1]);
        check({nm(2), ".err_cnt"}, {24'd0, ec2}, m_errs[2]);
        for (int i = 0; i < N; i++) begin
            check({nm(i), ".period_vld"}, {31'd0, vld[i]}, {31'd0, m_vld[i]});
            check({nm(i), ".locked"}, {31'd0, lk[i]}, (m_mode[i] == M_LOCK) ? 1 : 0);
            check({nm(i), ".err"}, {31'd0, er[i]}, {31'd0, m_err[i]});
        end
    endtask

    int b_err_seen;

    // One iteration per cycle, starting at a falling edge.
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            compare_all();
            if (er[1]) b_err_seen++;
            for (int i = 0; i < N; i++) begin
                if (g_pos[i] == 0) pick_gap(i);
                flag[i] = (g_pos[i] < g_wid[i]);
                g_pos[i]++;
                if (g_pos[i] == g_gap[i]) g_pos[i] = 0;
                model_step(i, flag[i]);
            end
            t++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst  = 1'b1;
        flag = '0;
        model_reset();
        gen_reset(0);
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Regular pulses with directed omissions/early pulses on instance a.
        run_cycles(200);
        for (int i = 0; i < N; i++) check({nm(i), ".locked_before_rst"}, {31'd0, lk[i]}, 1);

        // Asynchronous reset between clock edges must clear outputs immediately.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async.locked", {29'd0, lk}, 0);
        check("rst_async.period_a", {24'd0, po0}, 0);
        check("rst_async.err_cnt_a", {24'd0, ec0}, 0);
        check("rst_async.vld", {29'd0, vld}, 0);
        @(negedge clk);
        flag = '0;
        model_reset();
        gen_reset(1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Randomised gaps and duty cycles.
        run_cycles(1500);

        // Repeated lock/fault episodes on instance b to drive err_cnt into saturation.
        gen_reset(2);
        run_cycles(1800);
        b_err_seen = 0;
        run_cycles(40);
        check("b.err_cnt_saturated", {24'd0, ec1}, 255);
        check("b.err_pulses_after_sat", (b_err_seen > 0) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
